// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared definitions for the instruction-memory port arbiter:
//                default geometry, arbiter state encoding, owner encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    // Default memory geometry
    localparam int c_ADDR_W    = 5;
    localparam int c_DATA_W    = 32;
    localparam int c_MAX_BURST = 8;

    // Arbiter state encoding
    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_FETCH_OWN = 2'd1;
    localparam logic [1:0] c_ST_LOAD_OWN  = 2'd2;
    localparam logic [1:0] c_ST_YIELD     = 2'd3;

    // Owner encoding used for round-robin history and the read-return tag
    localparam logic c_OWN_FETCH  = 1'b0;
    localparam logic c_OWN_LOADER = 1'b1;

endpackage
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : imem_port_arbiter
//  Description : Shares the single synchronous instruction-memory port between
//                CPU fetch and the program loader / debug port. Grants are
//                combinational, read data returns one cycle after the grant
//                and is steered by a registered owner tag.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W    = c_ADDR_W,
    parameter int DATA_W    = c_DATA_W,
    parameter int MAX_BURST = c_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch side
    input  logic              f_req,
    input  logic [31:0]       f_pc,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_misalign,
    // loader side
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              l_lock,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              cpu_hold,
    // memory side
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int                 c_CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_BURST);

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_burst_cnt;
    logic                r_last_winner;
    logic                r_cpu_hold;
    logic                r_rv_valid;
    logic                r_rv_owner;
    logic [DATA_W-1:0]   r_f_rdata;
    logic [DATA_W-1:0]   r_l_rdata;

    logic                w_f_gnt;
    logic                w_l_gnt;
    logic [1:0]          w_next_state;
    logic [c_CNT_W-1:0]  w_next_cnt;
    logic [ADDR_W-1:0]   w_f_idx;
    logic                w_f_rvalid;
    logic                w_l_rvalid;
    logic                w_unused_pc_bits;

    // Byte PC to word index; high PC bits wrap modulo the memory depth.
    assign w_f_idx          = f_pc[ADDR_W+1:2];
    assign w_unused_pc_bits = ^f_pc[31:ADDR_W+2];

    // Grant decode; held at zero while reset is asserted so outputs stay quiet.
    always_comb begin
        w_f_gnt = 1'b0;
        w_l_gnt = 1'b0;
        if (rst_n) begin
            case (r_state)
                c_ST_LOAD_OWN: w_l_gnt = l_req;
                c_ST_YIELD:    w_f_gnt = f_req;
                default: begin
                    // Conflicts go to the side that did not win last time.
                    w_f_gnt = f_req & (~l_req | (r_last_winner == c_OWN_LOADER));
                    w_l_gnt = l_req & (~f_req | (r_last_winner == c_OWN_FETCH));
                end
            endcase
        end
    end

    // Next state and burst counter; the counter only measures fetch starvation.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_burst_cnt;
        case (r_state)
            c_ST_LOAD_OWN: begin
                if (!f_req) begin
                    w_next_cnt = '0;
                end else if (w_l_gnt) begin
                    w_next_cnt = r_burst_cnt + 1'b1;
                end
                if (!l_lock) begin
                    w_next_state = c_ST_IDLE;
                    w_next_cnt   = '0;
                end else if (f_req && (w_next_cnt >= c_MAX_CNT)) begin
                    w_next_state = c_ST_YIELD;
                end
            end
            c_ST_YIELD: begin
                w_next_cnt   = '0;
                w_next_state = l_lock ? c_ST_LOAD_OWN : c_ST_IDLE;
            end
            default: begin
                w_next_cnt = '0;
                if (w_l_gnt && l_lock) begin
                    w_next_state = c_ST_LOAD_OWN;
                end else if (w_f_gnt) begin
                    w_next_state = c_ST_FETCH_OWN;
                end else begin
                    w_next_state = c_ST_IDLE;
                end
            end
        endcase
    end

    // Arbiter state, round-robin history and the registered core stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_burst_cnt   <= '0;
            r_last_winner <= c_OWN_LOADER;
            r_cpu_hold    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_burst_cnt <= w_next_cnt;
            if (w_f_gnt || w_l_gnt) begin
                r_last_winner <= w_l_gnt ? c_OWN_LOADER : c_OWN_FETCH;
            end
            // Hold tracks the state being entered, so it rises with LOAD_OWN
            // and drops for exactly the YIELD cycle.
            r_cpu_hold <= (w_next_state == c_ST_LOAD_OWN);
        end
    end

    // Read-return tag plus per-side data holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rv_valid <= 1'b0;
            r_rv_owner <= c_OWN_FETCH;
            r_f_rdata  <= '0;
            r_l_rdata  <= '0;
        end else begin
            r_rv_valid <= (w_f_gnt | w_l_gnt) & ~(w_l_gnt & l_we);
            r_rv_owner <= w_l_gnt ? c_OWN_LOADER : c_OWN_FETCH;
            if (w_f_rvalid) r_f_rdata <= m_rdata;
            if (w_l_rvalid) r_l_rdata <= m_rdata;
        end
    end

    assign w_f_rvalid = r_rv_valid & (r_rv_owner == c_OWN_FETCH);
    assign w_l_rvalid = r_rv_valid & (r_rv_owner == c_OWN_LOADER);

    assign f_gnt      = w_f_gnt;
    assign l_gnt      = w_l_gnt;
    assign f_misalign = w_f_gnt & (|f_pc[1:0]);
    assign f_rvalid   = w_f_rvalid;
    assign l_rvalid   = w_l_rvalid;
    assign f_rdata    = w_f_rvalid ? m_rdata : r_f_rdata;
    assign l_rdata    = w_l_rvalid ? m_rdata : r_l_rdata;
    assign cpu_hold   = r_cpu_hold;

    assign m_en    = w_f_gnt | w_l_gnt;
    assign m_we    = w_l_gnt & l_we;
    assign m_addr  = w_f_gnt ? w_f_idx : (w_l_gnt ? l_addr : '0);
    assign m_wdata = w_l_gnt ? l_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_port_arbiter
//  Description : Self-checking bench for imem_port_arbiter with a behavioural
//                synchronous memory, a shadow copy of memory contents and
//                per-side read-data scoreboards.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_port_arbiter;

    localparam int c_AW = 5;
    localparam int c_DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            f_req;
    logic [31:0]     f_pc;
    logic            f_gnt, f_rvalid, f_misalign;
    logic [c_DW-1:0] f_rdata;
    logic            l_req, l_we, l_lock;
    logic [c_AW-1:0] l_addr;
    logic [c_DW-1:0] l_wdata;
    logic            l_gnt, l_rvalid, cpu_hold;
    logic [c_DW-1:0] l_rdata;
    logic            m_en, m_we;
    logic [c_AW-1:0] m_addr;
    logic [c_DW-1:0] m_wdata;
    logic [c_DW-1:0] m_rdata;

    logic [c_DW-1:0] mem    [32];
    logic [c_DW-1:0] shadow [32];
    logic [c_DW-1:0] fq[$];
    logic [c_DW-1:0] lq[$];

    int n_checks = 0;
    int n_errors = 0;

    logic            g_f, g_l, g_hold, g_mis;
    logic [c_AW-1:0] g_addr;

    always #5 clk = ~clk;

    imem_port_arbiter #(.ADDR_W(c_AW), .DATA_W(c_DW), .MAX_BURST(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_pc(f_pc), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_misalign(f_misalign),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .cpu_hold(cpu_hold),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    // Synchronous single-port memory with one-cycle read latency.
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata     <= mem[m_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic expect_g(input string tag, input logic ef, input logic el, input logic eh);
        chk({tag, " f_gnt"}, g_f, ef);
        chk({tag, " l_gnt"}, g_l, el);
        chk({tag, " cpu_hold"}, g_hold, eh);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " f_gnt"}, f_gnt, 0);
        chk({tag, " l_gnt"}, l_gnt, 0);
        chk({tag, " f_rvalid"}, f_rvalid, 0);
        chk({tag, " l_rvalid"}, l_rvalid, 0);
        chk({tag, " f_rdata"}, f_rdata, 0);
        chk({tag, " l_rdata"}, l_rdata, 0);
        chk({tag, " f_misalign"}, f_misalign, 0);
        chk({tag, " cpu_hold"}, cpu_hold, 0);
        chk({tag, " m_en"}, m_en, 0);
        chk({tag, " m_we"}, m_we, 0);
        chk({tag, " m_addr"}, m_addr, 0);
        chk({tag, " m_wdata"}, m_wdata, 0);
    endtask

    task automatic idle_inputs();
        f_req = 0; f_pc = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0; l_lock = 0;
    endtask

    // One clock cycle: inputs already driven (edge+1). Samples grants mid-cycle,
    // records scoreboard expectations, then checks read returns after the edge.
    task automatic cycle();
        logic [c_AW-1:0] fidx;
        logic            pf, pl;
        logic [c_DW-1:0] e;
        #4;
        g_f = f_gnt; g_l = l_gnt; g_hold = cpu_hold; g_addr = m_addr; g_mis = f_misalign;
        fidx = f_pc[6:2];
        if (f_gnt) begin
            chk("fetch m_addr", m_addr, fidx);
            chk("fetch m_we", m_we, 0);
            fq.push_back(shadow[fidx]);
        end
        if (l_gnt) begin
            chk("load m_addr", m_addr, l_addr);
            chk("load m_we", m_we, l_we);
            if (l_we) begin
                chk("load m_wdata", m_wdata, l_wdata);
                shadow[l_addr] = l_wdata;
            end else begin
                lq.push_back(shadow[l_addr]);
            end
        end
        pf = f_gnt;
        pl = l_gnt & ~l_we;
        @(posedge clk);
        #1;
        chk("f_rvalid", f_rvalid, pf);
        chk("l_rvalid", l_rvalid, pl);
        if (f_rvalid) begin
            if (fq.size() == 0) chk("f_rvalid unexpected", f_rvalid, 0);
            else begin e = fq.pop_front(); chk("f_rdata", f_rdata, e); end
        end
        if (l_rvalid) begin
            if (lq.size() == 0) chk("l_rvalid unexpected", l_rvalid, 0);
            else begin e = lq.pop_front(); chk("l_rdata", l_rdata, e); end
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        fq.delete();
        lq.delete();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]    = 32'hA000_0000 | i;
            shadow[i] = 32'hA000_0000 | i;
        end
        mem[3]    = 32'h8C08_0004;
        shadow[3] = 32'h8C08_0004;
        idle_inputs();
        rst_n = 0;

        // Reset state
        @(posedge clk);
        #1;
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1;

        // Fetch only
        f_req = 1; f_pc = 32'h0000_000C;
        cycle();
        expect_g("fetch", 1, 0, 0);
        chk("fetch m_addr word3", g_addr, 3);
        chk("fetch misalign", g_mis, 0);
        idle_inputs();
        cycle();
        chk("fetch rdata word3", f_rdata, 32'h8C08_0004);

        // Conflict alternation from reset: F, L, F, L
        do_reset();
        f_req = 1; f_pc = 32'h0000_0020; l_req = 1; l_we = 0; l_addr = 5;
        for (int i = 0; i < 4; i++) begin
            cycle();
            expect_g($sformatf("conflict%0d", i), (i % 2) == 0, (i % 2) == 1, 0);
        end
        idle_inputs();
        cycle();
        chk("conflict l_rdata", l_rdata, 32'hA000_0005);
        chk("conflict f_rdata", f_rdata, 32'hA000_0008);

        // Locked load of words 0..3, then read back word 2 while dropping lock
        do_reset();
        l_req = 1; l_lock = 1; l_we = 1; l_wdata = 32'h2008_0005;
        for (int i = 0; i < 4; i++) begin
            l_addr = i[4:0];
            if (i > 0) begin f_req = 1; f_pc = 0; end
            cycle();
            expect_g($sformatf("lock wr%0d", i), 0, 1, i > 0);
        end
        l_we = 0; l_addr = 2; l_lock = 0;
        cycle();
        expect_g("lock rd", 0, 1, 1);
        l_req = 0;
        cycle();
        expect_g("lock released", 1, 0, 0);
        chk("lock readback", l_rdata, 32'h2008_0005);
        idle_inputs();
        cycle();

        // Starvation: eight loader grants, one yield, loader resumes
        do_reset();
        l_req = 1; l_lock = 1; l_we = 1; l_addr = 16; l_wdata = 32'h5500_0000;
        cycle();
        expect_g("starve c0", 0, 1, 0);
        f_req = 1; f_pc = 32'h0000_0010;
        for (int i = 1; i <= 8; i++) begin
            l_addr = 5'(16 + i); l_wdata = 32'h5500_0000 + i;
            cycle();
            expect_g($sformatf("starve c%0d", i), 0, 1, 1);
        end
        l_addr = 30; l_wdata = 32'h5500_0009;
        cycle();
        expect_g("starve yield", 1, 0, 0);
        l_addr = 31; l_wdata = 32'h5500_000A;
        cycle();
        expect_g("starve resume", 0, 1, 1);
        idle_inputs();
        cycle();
        cycle();
        expect_g("starve idle", 0, 0, 0);

        // Address boundaries: misalignment and wrap
        do_reset();
        f_req = 1; f_pc = 32'h0000_0086;
        cycle();
        chk("pc86 gnt", g_f, 1);
        chk("pc86 m_addr", g_addr, 1);
        chk("pc86 misalign", g_mis, 1);
        f_pc = 32'h0000_0080;
        cycle();
        chk("pc80 m_addr", g_addr, 0);
        chk("pc80 misalign", g_mis, 0);
        idle_inputs();
        cycle();
        chk("idle misalign", g_mis, 0);

        // Reset asserted while a read return is outstanding
        do_reset();
        f_req = 1; f_pc = 32'h0000_000C;
        #4;
        chk("midrd gnt", f_gnt, 1);
        @(posedge clk);
        #1;
        f_req = 0;
        rst_n = 0;
        #1;
        chk_zero("midrd");
        @(posedge clk);
        #1;
        rst_n = 1;
        fq.delete();
        lq.delete();
        cycle();
        cycle();
        // IDLE with last winner = loader: a conflict goes to fetch, no hold
        f_req = 1; f_pc = 32'h0000_0004; l_req = 1; l_lock = 1; l_we = 0; l_addr = 7;
        cycle();
        expect_g("post-reset conflict", 1, 0, 0);
        idle_inputs();
        cycle();
        cycle();

        chk("fq drained", fq.size(), 0);
        chk("lq drained", lq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
